// File: rtl/beta_pkg.sv
`default_nettype none
// ============================================================================
// Module   : beta_pkg
// Purpose  : Shared opcode / ALU-function constants, the decoded-instruction
//            bundle type and the combinational Beta decode function.
//            Build option: BETA_MUL_EN makes MUL (0x22) / MULC (0x32) legal.
// Revision : 1.0  initial release
// ============================================================================
package beta_pkg;

    // Whether the multiplier opcodes are part of the implemented ISA
`ifdef BETA_MUL_EN
    localparam logic MUL_EN = 1'b1;
`else
    localparam logic MUL_EN = 1'b0;
`endif

    // Memory / control opcodes
    localparam logic [5:0] OP_LD    = 6'h18;
    localparam logic [5:0] OP_ST    = 6'h19;
    localparam logic [5:0] OP_JMP   = 6'h1B;
    localparam logic [5:0] OP_BEQ   = 6'h1C;
    localparam logic [5:0] OP_BNE   = 6'h1D;
    localparam logic [5:0] OP_LDR   = 6'h1F;
    // Register-register ALU opcodes
    localparam logic [5:0] OP_ADD   = 6'h20;
    localparam logic [5:0] OP_SUB   = 6'h21;
    localparam logic [5:0] OP_MUL   = 6'h22;
    localparam logic [5:0] OP_CMPEQ = 6'h24;
    localparam logic [5:0] OP_CMPLT = 6'h25;
    localparam logic [5:0] OP_CMPLE = 6'h26;
    localparam logic [5:0] OP_AND   = 6'h28;
    localparam logic [5:0] OP_OR    = 6'h29;
    localparam logic [5:0] OP_XOR   = 6'h2A;
    localparam logic [5:0] OP_XNOR  = 6'h2B;
    localparam logic [5:0] OP_SHL   = 6'h2C;
    localparam logic [5:0] OP_SHR   = 6'h2D;
    localparam logic [5:0] OP_SRA   = 6'h2E;
    // Register-literal ALU opcodes
    localparam logic [5:0] OP_ADDC   = 6'h30;
    localparam logic [5:0] OP_SUBC   = 6'h31;
    localparam logic [5:0] OP_MULC   = 6'h32;
    localparam logic [5:0] OP_CMPEQC = 6'h34;
    localparam logic [5:0] OP_CMPLTC = 6'h35;
    localparam logic [5:0] OP_CMPLEC = 6'h36;
    localparam logic [5:0] OP_ANDC   = 6'h38;
    localparam logic [5:0] OP_ORC    = 6'h39;
    localparam logic [5:0] OP_XORC   = 6'h3A;
    localparam logic [5:0] OP_XNORC  = 6'h3B;
    localparam logic [5:0] OP_SHLC   = 6'h3C;
    localparam logic [5:0] OP_SHRC   = 6'h3D;
    localparam logic [5:0] OP_SRAC   = 6'h3E;

    // ALU function codes understood by Beta_ALU
    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_MUL   = 4'b0010;
    localparam logic [3:0] ALU_CMPEQ = 4'b0100;
    localparam logic [3:0] ALU_CMPLT = 4'b0101;
    localparam logic [3:0] ALU_CMPLE = 4'b0110;
    localparam logic [3:0] ALU_AND   = 4'b1000;
    localparam logic [3:0] ALU_OR    = 4'b1001;
    localparam logic [3:0] ALU_XOR   = 4'b1010;
    localparam logic [3:0] ALU_XNOR  = 4'b1011;
    localparam logic [3:0] ALU_SHL   = 4'b1100;
    localparam logic [3:0] ALU_SHR   = 4'b1101;
    localparam logic [3:0] ALU_SRA   = 4'b1110;

    // Register the illegal-op trap writes its return address into (XP)
    localparam logic [4:0] REG_XP = 5'd30;

    typedef struct packed {
        logic [3:0]  alufn;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [4:0]  rc;
        logic [31:0] lit;
        logic        bsel;
        logic        wen;
        logic        memrd;
        logic        memwr;
        logic        branch;
        logic        jmp;
        logic        ldr;
        logic        illop;
    } beta_dec_t;

    localparam int DEC_W = $bits(beta_dec_t);

    function automatic beta_dec_t beta_decode_fn(input logic [31:0] instr);
        beta_dec_t  d;
        logic [5:0] op;
        logic [3:0] fn;
        logic       is_alu;
        logic       legal;
        op     = instr[31:26];
        fn     = ALU_ADD;
        is_alu = 1'b1;
        legal  = 1'b1;
        d      = '0;
        d.ra   = instr[20:16];
        d.rb   = instr[15:11];
        d.rc   = instr[25:21];
        d.lit  = {{16{instr[15]}}, instr[15:0]};

        // Map both ALU opcode groups onto their function code
        unique case (op)
            OP_ADD,   OP_ADDC:   fn = ALU_ADD;
            OP_SUB,   OP_SUBC:   fn = ALU_SUB;
            OP_MUL,   OP_MULC:   begin fn = ALU_MUL; legal = MUL_EN; end
            OP_CMPEQ, OP_CMPEQC: fn = ALU_CMPEQ;
            OP_CMPLT, OP_CMPLTC: fn = ALU_CMPLT;
            OP_CMPLE, OP_CMPLEC: fn = ALU_CMPLE;
            OP_AND,   OP_ANDC:   fn = ALU_AND;
            OP_OR,    OP_ORC:    fn = ALU_OR;
            OP_XOR,   OP_XORC:   fn = ALU_XOR;
            OP_XNOR,  OP_XNORC:  fn = ALU_XNOR;
            OP_SHL,   OP_SHLC:   fn = ALU_SHL;
            OP_SHR,   OP_SHRC:   fn = ALU_SHR;
            OP_SRA,   OP_SRAC:   fn = ALU_SRA;
            default:             is_alu = 1'b0;
        endcase

        if (is_alu) begin
            // Opcode bit 4 separates the literal group (0x3x) from 0x2x
            d.alufn = fn;
            d.bsel  = op[4];
            d.wen   = 1'b1;
        end else begin
            legal = 1'b1;
            unique case (op)
                OP_LD:  begin d.bsel = 1'b1; d.memrd = 1'b1; d.wen = 1'b1; end
                OP_ST:  begin d.bsel = 1'b1; d.memwr = 1'b1; d.rb = instr[25:21]; end
                OP_JMP: begin d.jmp = 1'b1; d.wen = 1'b1; end
                OP_BEQ,
                OP_BNE: begin d.branch = 1'b1; d.wen = 1'b1; end
                OP_LDR: begin d.ldr = 1'b1; d.memrd = 1'b1; d.wen = 1'b1; end
                default: legal = 1'b0;
            endcase
        end

        // Illegal opcodes trap: only the XP write survives
        if (!legal) begin
            d.alufn  = ALU_ADD;
            d.bsel   = 1'b0;
            d.memrd  = 1'b0;
            d.memwr  = 1'b0;
            d.branch = 1'b0;
            d.jmp    = 1'b0;
            d.ldr    = 1'b0;
            d.illop  = 1'b1;
            d.rc     = REG_XP;
            d.wen    = 1'b1;
        end
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/beta_skid_buffer.sv
`default_nettype none
// ============================================================================
// Module   : beta_skid_buffer
// Purpose  : Two-entry valid/ready pipeline register (main + skid) giving
//            full throughput with a registered upstream ready.
// Revision : 1.0  initial release
// ============================================================================
module beta_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data
);

    logic             r_main_valid;
    logic             r_skid_valid;
    logic [WIDTH-1:0] r_main_data;
    logic [WIDTH-1:0] r_skid_data;
    logic             w_in_hs;
    logic             w_main_free;

    // Skid entry only ever fills while main is held, so !skid is the ready
    assign w_in_hs     = i_valid & ~r_skid_valid;
    assign w_main_free = ~r_main_valid | i_ready;

    assign o_ready = ~r_skid_valid;
    assign o_valid = r_main_valid;
    assign o_data  = r_main_data;

    // Main register refills from skid first (FIFO order), else from input
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_main_data  <= '0;
            r_skid_data  <= '0;
        end else if (i_flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_main_free) begin
            if (r_skid_valid) begin
                r_main_data  <= r_skid_data;
                r_main_valid <= 1'b1;
                r_skid_valid <= 1'b0;
            end else if (w_in_hs) begin
                r_main_data  <= i_data;
                r_main_valid <= 1'b1;
            end else begin
                r_main_valid <= 1'b0;
            end
        end else if (w_in_hs) begin
            r_skid_data  <= i_data;
            r_skid_valid <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/beta_decode.sv
`default_nettype none
// ============================================================================
// Module   : beta_decode
// Purpose  : Beta CPU instruction-decode pipeline stage. Decodes each word
//            into ALU/control fields and forwards it through a skid buffer.
//            Build option: BETA_MUL_EN enables the MUL/MULC opcodes.
// Revision : 1.0  initial release
// ============================================================================
module beta_decode
    import beta_pkg::*;
#(
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      out_alufn,
    output logic [4:0]      out_ra,
    output logic [4:0]      out_rb,
    output logic [4:0]      out_rc,
    output logic [31:0]     out_lit,
    output logic            out_bsel,
    output logic            out_wen,
    output logic            out_memrd,
    output logic            out_memwr,
    output logic            out_branch,
    output logic            out_jmp,
    output logic            out_ldr,
    output logic            out_illop,
    output logic [PC_W-1:0] out_pc
);

    localparam int PAY_W = DEC_W + PC_W;

    beta_dec_t        w_in_dec;
    beta_dec_t        w_out_dec;
    logic [PAY_W-1:0] w_in_payload;
    logic [PAY_W-1:0] w_out_payload;

    // Decode ahead of the register so the stage adds one cycle of latency
    assign w_in_dec     = beta_decode_fn(in_instr);
    assign w_in_payload = {w_in_dec, in_pc};

    beta_skid_buffer #(
        .WIDTH (PAY_W)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (flush),
        .i_valid (in_valid),
        .o_ready (in_ready),
        .i_data  (w_in_payload),
        .o_valid (out_valid),
        .i_ready (out_ready),
        .o_data  (w_out_payload)
    );

    assign w_out_dec  = w_out_payload[PAY_W-1:PC_W];
    assign out_pc     = w_out_payload[PC_W-1:0];
    assign out_alufn  = w_out_dec.alufn;
    assign out_ra     = w_out_dec.ra;
    assign out_rb     = w_out_dec.rb;
    assign out_rc     = w_out_dec.rc;
    assign out_lit    = w_out_dec.lit;
    assign out_bsel   = w_out_dec.bsel;
    assign out_wen    = w_out_dec.wen;
    assign out_memrd  = w_out_dec.memrd;
    assign out_memwr  = w_out_dec.memwr;
    assign out_branch = w_out_dec.branch;
    assign out_jmp    = w_out_dec.jmp;
    assign out_ldr    = w_out_dec.ldr;
    assign out_illop  = w_out_dec.illop;

endmodule
`default_nettype wire

// File: tb/tb_beta_decode.sv
`default_nettype none
// ============================================================================
// Module   : tb_beta_decode
// Purpose  : Self-checking bench for beta_decode: directed decode vectors,
//            backpressure / flush scenarios and randomized traffic against
//            a queue-based reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_beta_decode;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_alufn;
    logic [4:0]  out_ra;
    logic [4:0]  out_rb;
    logic [4:0]  out_rc;
    logic [31:0] out_lit;
    logic        out_bsel;
    logic        out_wen;
    logic        out_memrd;
    logic        out_memwr;
    logic        out_branch;
    logic        out_jmp;
    logic        out_ldr;
    logic        out_illop;
    logic [31:0] out_pc;

    typedef struct packed {
        logic [3:0]  alufn;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [4:0]  rc;
        logic [31:0] lit;
        logic        bsel;
        logic        wen;
        logic        memrd;
        logic        memwr;
        logic        branch;
        logic        jmp;
        logic        ldr;
        logic        illop;
        logic [31:0] pc;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    beta_decode #(.PC_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_pc      (in_pc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_alufn  (out_alufn),
        .out_ra     (out_ra),
        .out_rb     (out_rb),
        .out_rc     (out_rc),
        .out_lit    (out_lit),
        .out_bsel   (out_bsel),
        .out_wen    (out_wen),
        .out_memrd  (out_memrd),
        .out_memwr  (out_memwr),
        .out_branch (out_branch),
        .out_jmp    (out_jmp),
        .out_ldr    (out_ldr),
        .out_illop  (out_illop),
        .out_pc     (out_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    // Reference decode written directly from the ISA rules
    function automatic exp_t ref_model(input logic [31:0] instr, input logic [31:0] pc);
        exp_t    e;
        int      op;
        int      fn;
        bit      fn_ok;
        bit      mul_en;
        shortint s;
`ifdef BETA_MUL_EN
        mul_en = 1'b1;
`else
        mul_en = 1'b0;
`endif
        op  = int'(instr[31:26]);
        fn  = op % 16;
        s   = shortint'(instr[15:0]);
        e   = '0;
        e.ra  = instr[20:16];
        e.rb  = instr[15:11];
        e.rc  = instr[25:21];
        e.lit = 32'(int'(s));
        e.pc  = pc;
        fn_ok = (fn inside {0, 1, 4, 5, 6, 8, 9, 10, 11, 12, 13, 14}) || (fn == 2 && mul_en);
        if ((op / 16 == 2 || op / 16 == 3) && fn_ok) begin
            e.alufn = 4'(fn);
            e.bsel  = (op >= 48);
            e.wen   = 1'b1;
        end else begin
            case (op)
                24: begin e.bsel = 1'b1; e.memrd = 1'b1; e.wen = 1'b1; end
                25: begin e.bsel = 1'b1; e.memwr = 1'b1; e.rb = instr[25:21]; end
                27: begin e.jmp = 1'b1; e.wen = 1'b1; end
                28, 29: begin e.branch = 1'b1; e.wen = 1'b1; end
                31: begin e.ldr = 1'b1; e.memrd = 1'b1; e.wen = 1'b1; end
                default: begin e.illop = 1'b1; e.rc = 5'd30; e.wen = 1'b1; end
            endcase
        end
        return e;
    endfunction

    function automatic exp_t observed();
        exp_t o;
        o = '{out_alufn, out_ra, out_rb, out_rc, out_lit, out_bsel, out_wen, out_memrd,
              out_memwr, out_branch, out_jmp, out_ldr, out_illop, out_pc};
        return o;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 13))
            0:  w[31:26] = 6'h18;
            1:  w[31:26] = 6'h19;
            2:  w[31:26] = 6'h1B;
            3:  w[31:26] = 6'h1C;
            4:  w[31:26] = 6'h1D;
            5:  w[31:26] = 6'h1F;
            6:  w[31:26] = 6'h22;
            7:  w[31:26] = 6'h32;
            8:  w[31:26] = 6'h23;
            9:  w[31:26] = 6'h2F;
            10: w[31:26] = 6'h20 + 6'($urandom_range(0, 15));
            11: w[31:26] = 6'h30 + 6'($urandom_range(0, 15));
            default: ;
        endcase
        return w;
    endfunction

    // One clock: advance the model with pre-edge inputs, then compare
    task automatic step();
        bit in_hs;
        bit out_hs;
        if (!rst_n || flush) begin
            q.delete();
        end else begin
            in_hs  = in_valid && (q.size() < 2);
            out_hs = (q.size() > 0) && out_ready;
            if (out_hs) void'(q.pop_front());
            if (in_hs) q.push_back(ref_model(in_instr, in_pc));
        end
        @(posedge clk);
        #1;
        chk("in_ready", in_ready, q.size() < 2);
        chk("out_valid", out_valid, q.size() > 0);
        if (q.size() > 0) chk("bundle", observed(), q[0]);
    endtask

    task automatic directed(input logic [31:0] instr);
        in_instr  = instr;
        in_pc     = $urandom;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid  = 1'b0;
    endtask

    logic [31:0] bp_instr [4];

    initial begin
        int idx;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_instr  = 32'h80611000;
        in_pc     = 32'h100;

        // Reset with handshakes offered
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_bundle", observed(), '0);
        end
        in_valid = 1'b0;
        rst_n    = 1'b1;
        step();
        chk("post_rst_bundle", observed(), '0);

        // Directed decode vectors
        directed(32'h80611000);
        chk("add_alufn", out_alufn, 4'b0000);
        chk("add_regs", {out_ra, out_rb, out_rc}, {5'd1, 5'd2, 5'd3});
        chk("add_bsel_wen", {out_bsel, out_wen}, 2'b01);

        directed(32'hC061FFFC);
        chk("addc_lit", out_lit, 32'hFFFFFFFC);
        chk("addc_bsel_alufn", {out_bsel, out_alufn}, 5'b1_0000);

        directed(32'h64611234);
        chk("st_memwr_wen", {out_memwr, out_wen}, 2'b10);
        chk("st_rb", out_rb, 5'd3);
        chk("st_lit", out_lit, 32'h00001234);

        directed(32'h8C000000);
        chk("ill23", {out_illop, out_rc, out_wen}, {1'b1, 5'd30, 1'b1});

        directed(32'h88611000);
`ifdef BETA_MUL_EN
        chk("mul_legal", {out_alufn, out_illop}, {4'b0010, 1'b0});
`else
        chk("mul_illegal", {out_illop, out_rc}, {1'b1, 5'd30});
`endif
        step();

        // Backpressure: 3 cycles stalled, then drain
        for (int i = 0; i < 4; i++) bp_instr[i] = rand_instr();
        idx = 0;
        for (int c = 0; c < 8; c++) begin
            out_ready = (c >= 3);
            in_valid  = (idx < 4);
            in_instr  = bp_instr[idx % 4];
            in_pc     = 32'h2000 + 32'(idx * 4);
            if (c >= 3 && c <= 6) chk("bp_nogap", out_valid, 1'b1);
            if (in_valid && q.size() < 2) idx++;
            step();
            if (c == 1) chk("bp_full_ready", in_ready, 1'b0);
        end
        chk("bp_all_accepted", idx, 4);
        in_valid = 1'b0;

        // Flush with both entries full and an input offered
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_instr = rand_instr();
            in_pc    = 32'h3000 + 32'(i * 4);
            step();
        end
        flush    = 1'b1;
        in_pc    = 32'h3008;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_ovalid", out_valid, 1'b0);
        chk("flush_iready", in_ready, 1'b1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
        in_valid = 1'b1;
        in_instr = 32'h80611000;
        in_pc    = 32'h4000;
        step();
        in_valid = 1'b0;
        chk("post_flush_pc", out_pc, 32'h4000);

        // Randomized traffic
        for (int c = 0; c < 500; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_instr  = rand_instr();
            in_pc     = $urandom;
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 40) == 0);
            step();
        end
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
